axi_rd_arbiter: RTL
===================

Name: axi_rd_arbiter

Overview:
- Shares the single AXI read channel between the icache refill port and the dcache refill/uncached-load port.
- The icache is the port that feeds `icache_data_ok` and `icache_rdata` into the IF stage.
- One burst is in flight at a time. A 3-state FSM sequences address and data phases and routes R beats to the owning requester.
- Sits between the L1 caches and the top-level AXI master interface.

Parameters:
- ADDR_W, 32, address width of requests and `araddr`.
- DATA_W, 32, data width of R beats and requester data.
- LEN_W, 8, burst length field width (AXI4 `arlen`, beats-1).

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- ic_req  in  1  icache read request; held with addr/len stable until ic_gnt
- ic_addr  in  ADDR_W  icache burst start address
- ic_len  in  LEN_W  icache burst length (beats-1)
- ic_gnt  out  1  one-cycle pulse: icache request accepted on AR
- ic_rvalid  out  1  icache data beat valid
- ic_rlast  out  1  last beat of icache burst
- ic_rdata  out  DATA_W  icache beat data
- dc_req, dc_addr, dc_len, dc_gnt, dc_rvalid, dc_rlast, dc_rdata  same as ic_*, for the dcache
- arid  out  4  0 = icache, 1 = dcache
- araddr  out  ADDR_W  latched request address
- arlen  out  LEN_W  latched request length
- arsize  out  3  constant 3'b010
- arburst  out  2  constant 2'b01 (INCR)
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  ignored for routing
- rdata  in  DATA_W  R data
- rlast  in  1  R last
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- FSM states:
  - IDLE: arvalid=0, rready=0. If ic_req or dc_req, pick an owner (dc has fixed priority), latch addr/len/owner, go to ADDR.
  - ADDR: arvalid=1; araddr/arlen/arid come from the latch and stay stable. When arvalid && arready, pulse the owner's gnt for that same cycle and go to DATA.
  - DATA: rready=1. Every beat with rvalid is forwarded combinationally to the owner: owner_rvalid=rvalid, owner_rlast=rlast, owner_rdata=rdata. The non-owner's rvalid stays 0. When rvalid && rlast, go to IDLE.
- Latency:
  - req first seen in IDLE at cycle N → arvalid=1 at N+1.
  - rlast beat at cycle M → IDLE at M+1 → the next arvalid is at M+2 at the earliest.
- Simultaneous ic_req and dc_req in IDLE: dc wins. ic stays pending and is served on the next IDLE pass.
- A req that arrives while the FSM is in ADDR or DATA is not sampled until IDLE.
- Deasserting req before gnt is illegal and is not checked.
- arlen=0 (single beat): one beat with rlast=1 returns the FSM to IDLE.
- rready is held at 1 for the whole of DATA; the arbiter never back-pressures R.
- R beats arriving while not in DATA: rready=0, so they are not accepted.
- Reset (any state, mid-burst included):
  - next state IDLE; arvalid=0, rready=0; all gnt/rvalid/rlast=0.
  - latched addr/len/owner and arid = 0.
  - The slave shares the same reset, so no drain is performed.
- Data outputs ic_rdata/dc_rdata both carry rdata unconditionally; only the valids are qualified.

Optional Feature:
- Macro: RD_ARB_ROUND_ROBIN_EN.
- When defined:
  - a 1-bit last_owner register (reset 0 = icache) is updated at each AR handshake.
  - On simultaneous requests in IDLE, the port that is not last_owner wins.
  - A single request is granted immediately regardless of last_owner.
- When undefined: fixed dcache priority as above, and no last_owner register exists.

Test Plan:
- Only ic_req with addr 0x1FC0_0000, len 7; arready=1 immediately; 8 rvalid beats with data 0..7 and rlast on beat 8 → arvalid at N+1, arid=0, arlen=7, ic_gnt pulse in that cycle, ic_rvalid×8 with matching data, ic_rlast on beat 8, dc_rvalid=0 throughout, IDLE next cycle.
- ic_req and dc_req in the same cycle (dc addr 0x0000_1000, len 3) → dc burst first with arid=1. ic AR starts 2 cycles after the dc rlast. With RD_ARB_ROUND_ROBIN_EN, a second simultaneous pair is granted to the opposite port from the last winner.
- arready held low 5 cycles → arvalid stays 1 with araddr/arlen stable, no gnt; gnt pulses exactly in the arready cycle.
- dc_req with len 0 → single beat, dc_rvalid=dc_rlast=1 in one cycle, return to IDLE.
- reset asserted during beat 3 of an 8-beat ic burst → next cycle all outputs 0 and state IDLE. An ic_req after reset restarts cleanly with arid=0.
- rvalid gaps (beats spaced 1–3 idle cycles) → rready stays 1, no spurious ic_rvalid in gap cycles.

Source files
------------

// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: icache/dcache refill requests plus the shared AXI read channel.
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W = 8
);
  logic ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic [LEN_W-1:0] ic_len;
  logic ic_gnt;
  logic ic_rvalid;
  logic ic_rlast;
  logic [DATA_W-1:0] ic_rdata;
  logic dc_req;
  logic [ADDR_W-1:0] dc_addr;
  logic [LEN_W-1:0] dc_len;
  logic dc_gnt;
  logic dc_rvalid;
  logic dc_rlast;
  logic [DATA_W-1:0] dc_rdata;
  logic [3:0] arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid;
  logic arready;
  logic [3:0] rid;
  logic [DATA_W-1:0] rdata;
  logic rlast;
  logic rvalid;
  logic rready;
  modport master (
    input ic_req, ic_addr, ic_len, dc_req, dc_addr, dc_len,
    input arready, rid, rdata, rlast, rvalid,
    output ic_gnt, ic_rvalid, ic_rlast, ic_rdata,
    output dc_gnt, dc_rvalid, dc_rlast, dc_rdata,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready
  );
  modport slave (
    output ic_req, ic_addr, ic_len, dc_req, dc_addr, dc_len,
    output arready, rid, rdata, rlast, rvalid,
    input ic_gnt, ic_rvalid, ic_rlast, ic_rdata,
    input dc_gnt, dc_rvalid, dc_rlast, dc_rdata,
    input arid, araddr, arlen, arsize, arburst, arvalid, rready
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: one-burst-at-a-time AXI read arbiter between icache and dcache refills.
// Define RD_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests (default: dcache priority).
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W = 8
) (
  input logic clk,
  input logic reset,
  axi_rd_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state;
  logic owner;
  logic pick_dc;
  logic ar_hs;
  logic r_beat;
  logic unused_rid;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0] len_q;
  assign ar_hs = state == ADDR && bus.arready;
  assign r_beat = state == DATA && bus.rvalid;
  assign unused_rid = ^bus.rid;
`ifdef RD_ARB_ROUND_ROBIN_EN
  logic last_owner;
  assign pick_dc = bus.dc_req && (!bus.ic_req || !last_owner);
  always_ff @(posedge clk)
    if (reset) last_owner <= 1'b0;
    else if (ar_hs) last_owner <= owner;
`else
  assign pick_dc = bus.dc_req;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      addr_q <= '0;
      len_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.ic_req || bus.dc_req) begin
          state <= ADDR;
          owner <= pick_dc;
          addr_q <= pick_dc ? bus.dc_addr : bus.ic_addr;
          len_q <= pick_dc ? bus.dc_len : bus.ic_len;
        end
        ADDR: if (bus.arready) state <= DATA;
        DATA: if (bus.rvalid && bus.rlast) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    bus.arvalid = state == ADDR;
    bus.rready = state == DATA;
    bus.arid = {3'b000, owner};
    bus.araddr = addr_q;
    bus.arlen = len_q;
    bus.arsize = 3'b010;
    bus.arburst = 2'b01;
    bus.ic_gnt = ar_hs && !owner;
    bus.dc_gnt = ar_hs && owner;
    bus.ic_rvalid = r_beat && !owner;
    bus.dc_rvalid = r_beat && owner;
    bus.ic_rlast = r_beat && !owner && bus.rlast;
    bus.dc_rlast = r_beat && owner && bus.rlast;
    bus.ic_rdata = bus.rdata;
    bus.dc_rdata = bus.rdata;
  end
endmodule
